// File: rtl/ex_muldiv_pkg.sv
// Shared encodings for the iterative RV32M multiply/divide unit:
// M-op funct3 codes, the stall code it raises, and FSM state encodings.
package ex_muldiv_pkg;

    localparam int REG_ADDR_WIDTH = 5;
    localparam int REG_DATA_WIDTH = 32;

    localparam logic [2:0] MD_MUL    = 3'b000;
    localparam logic [2:0] MD_MULH   = 3'b001;
    localparam logic [2:0] MD_MULHSU = 3'b010;
    localparam logic [2:0] MD_MULHU  = 3'b011;
    localparam logic [2:0] MD_DIV    = 3'b100;
    localparam logic [2:0] MD_DIVU   = 3'b101;
    localparam logic [2:0] MD_REM    = 3'b110;
    localparam logic [2:0] MD_REMU   = 3'b111;

    localparam logic [2:0] STALL_MULDIV = 3'd4;

    typedef enum logic [1:0] {
        MD_IDLE = 2'd0,
        MD_CALC = 2'd1,
        MD_DONE = 2'd2
    } md_state_e;

    function automatic logic op_signed_rs1(input logic [2:0] f);
        return (f == MD_MULH) || (f == MD_MULHSU) || (f == MD_DIV) || (f == MD_REM);
    endfunction

    function automatic logic op_signed_rs2(input logic [2:0] f);
        return (f == MD_MULH) || (f == MD_DIV) || (f == MD_REM);
    endfunction

endpackage

// File: rtl/muldiv_iter.sv
// One combinational iteration of the multiply (shift-add) or divide
// (restoring shift-subtract) datapath, plus the final sign-fix/select network.
module muldiv_iter
    import ex_muldiv_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            is_div,
    input  logic [XLEN-1:0] hi,
    input  logic [XLEN-1:0] lo,
    input  logic [XLEN-1:0] b,
    input  logic [2:0]      op,
    input  logic            s1,
    input  logic            s2,
    output logic [XLEN-1:0] hi_next,
    output logic [XLEN-1:0] lo_next,
    output logic [XLEN-1:0] fixed
);

    function automatic logic [XLEN-1:0] cond_neg(input logic [XLEN-1:0] v, input logic n);
        return n ? -v : v;
    endfunction

    function automatic logic [2*XLEN-1:0] cond_neg_wide(input logic [2*XLEN-1:0] v, input logic n);
        return n ? -v : v;
    endfunction

    logic [XLEN:0]     sum;
    logic [XLEN:0]     shifted;
    logic [XLEN:0]     diff;
    logic              fits;
    logic              unused_diff_top;
    logic [2*XLEN-1:0] prod_fix;
    logic [XLEN-1:0]   quot_fix;
    logic [XLEN-1:0]   rem_fix;

    assign unused_diff_top = diff[XLEN];

    always_comb begin
        sum     = {1'b0, hi} + (lo[0] ? {1'b0, b} : '0);
        shifted = {hi, lo[XLEN-1]};
        diff    = shifted - {1'b0, b};
        fits    = (shifted >= {1'b0, b});
        if (is_div) begin
            // Remainder after a successful subtract is below the divisor, so XLEN bits suffice.
            hi_next = fits ? diff[XLEN-1:0] : shifted[XLEN-1:0];
            lo_next = {lo[XLEN-2:0], fits};
        end else begin
            hi_next = sum[XLEN:1];
            lo_next = {sum[0], lo[XLEN-1:1]};
        end
    end

    always_comb begin
        prod_fix = cond_neg_wide({hi, lo}, s1 ^ s2);
        quot_fix = cond_neg(lo, s1 ^ s2);
        rem_fix  = cond_neg(hi, s1);
        case (op)
            MD_MUL:                     fixed = prod_fix[XLEN-1:0];
            MD_MULH, MD_MULHSU, MD_MULHU: fixed = prod_fix[2*XLEN-1:XLEN];
            MD_DIV, MD_DIVU:            fixed = quot_fix;
            default:                    fixed = rem_fix;
        endcase
    end

endmodule

// File: rtl/ex_muldiv.sv
// EX-stage iterative RV32M unit: 32-cycle multiply/divide with a one-cycle
// fast path for divide-by-zero and signed overflow; stalls the pipe via busy.
module ex_muldiv
    import ex_muldiv_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int CNT_W = 6
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    input  logic [2:0]                op,
    input  logic [XLEN-1:0]           rs1_data,
    input  logic [XLEN-1:0]           rs2_data,
    input  logic [REG_ADDR_WIDTH-1:0] rd_addr_ex,
    input  logic                      flush,
    output logic                      busy,
    output logic                      done,
    output logic [XLEN-1:0]           result,
    output logic [REG_ADDR_WIDTH-1:0] rd_addr
);

    function automatic logic [XLEN-1:0] cond_neg(input logic [XLEN-1:0] v, input logic n);
        return n ? -v : v;
    endfunction

    md_state_e                 state_q, state_d;
    logic [CNT_W-1:0]          cnt_q;
    logic [2:0]                op_q;
    logic                      s1_q, s2_q, fast_q;
    logic [REG_ADDR_WIDTH-1:0] rd_q, rd_hold_q;
    logic [XLEN-1:0]           res_hold_q;
    logic [XLEN-1:0]           hi_q, lo_q, b_q;

    logic                      accept;
    logic                      s1_in, s2_in;
    logic [XLEN-1:0]           a_mag, b_mag;
    logic                      div_zero, div_ovf, fast_in;
    logic [XLEN-1:0]           fast_val;
    logic [XLEN-1:0]           hi_next, lo_next, iter_fixed, final_res;

    always_comb begin
        accept   = start && !flush;
        s1_in    = op_signed_rs1(op) && rs1_data[XLEN-1];
        s2_in    = op_signed_rs2(op) && rs2_data[XLEN-1];
        a_mag    = cond_neg(rs1_data, s1_in);
        b_mag    = cond_neg(rs2_data, s2_in);
        div_zero = op[2] && (rs2_data == '0);
        div_ovf  = ((op == MD_DIV) || (op == MD_REM)) &&
                   (rs1_data == {1'b1, {(XLEN-1){1'b0}}}) && (rs2_data == '1);
        fast_in  = div_zero || div_ovf;
        // op[1] separates REM/REMU from DIV/DIVU in the divide half of funct3.
        if (div_zero) fast_val = op[1] ? rs1_data : '1;
        else          fast_val = op[1] ? '0 : rs1_data;
    end

    muldiv_iter #(.XLEN(XLEN)) u_iter (
        .is_div  (op_q[2]),
        .hi      (hi_q),
        .lo      (lo_q),
        .b       (b_q),
        .op      (op_q),
        .s1      (s1_q),
        .s2      (s2_q),
        .hi_next (hi_next),
        .lo_next (lo_next),
        .fixed   (iter_fixed)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            MD_IDLE: if (accept) state_d = fast_in ? MD_DONE : MD_CALC;
            MD_CALC: begin
                if (flush)               state_d = MD_IDLE;
                else if (cnt_q == '0)    state_d = MD_DONE;
            end
            MD_DONE: state_d = MD_IDLE;
            default: state_d = MD_IDLE;
        endcase
    end

    always_comb begin
        busy      = rst && (((state_q == MD_IDLE) && accept) || (state_q == MD_CALC));
        done      = (state_q == MD_DONE) && !flush;
        final_res = fast_q ? lo_q : iter_fixed;
        result    = done ? final_res : res_hold_q;
        rd_addr   = done ? rd_q : rd_hold_q;
    end

    // Control and architecturally visible holding registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= MD_IDLE;
            cnt_q      <= '0;
            op_q       <= MD_MUL;
            s1_q       <= 1'b0;
            s2_q       <= 1'b0;
            fast_q     <= 1'b0;
            rd_q       <= '0;
            res_hold_q <= '0;
            rd_hold_q  <= '0;
        end else begin
            state_q <= state_d;
            if ((state_q == MD_IDLE) && accept) begin
                cnt_q  <= CNT_W'(XLEN - 1);
                op_q   <= op;
                s1_q   <= s1_in;
                s2_q   <= s2_in;
                fast_q <= fast_in;
                rd_q   <= rd_addr_ex;
            end else if ((state_q == MD_CALC) && (cnt_q != '0)) begin
                cnt_q <= cnt_q - 1'b1;
            end
            if (done) begin
                res_hold_q <= final_res;
                rd_hold_q  <= rd_q;
            end
        end
    end

    // Datapath registers: {hi, lo} is the product accumulator or {remainder, quotient}.
    always_ff @(posedge clk) begin
        if ((state_q == MD_IDLE) && accept) begin
            hi_q <= '0;
            if (fast_in) begin
                lo_q <= fast_val;
                b_q  <= b_mag;
            end else if (op[2]) begin
                lo_q <= a_mag;
                b_q  <= b_mag;
            end else begin
                lo_q <= b_mag;
                b_q  <= a_mag;
            end
        end else if (state_q == MD_CALC) begin
            hi_q <= hi_next;
            lo_q <= lo_next;
        end
    end

endmodule

// File: tb/tb_ex_muldiv.sv
// Directed bench for ex_muldiv: table of M-ops with hand-computed results
// and latencies, plus flush, flush+start and mid-operation reset sequences.
module tb_ex_muldiv;

    logic        clk;
    logic        rst;
    logic        start;
    logic [2:0]  op;
    logic [31:0] rs1_data;
    logic [31:0] rs2_data;
    logic [4:0]  rd_addr_ex;
    logic        flush;
    logic        busy;
    logic        done;
    logic [31:0] result;
    logic [4:0]  rd_addr;

    int total;
    int bad;

    ex_muldiv #(.XLEN(32), .CNT_W(6)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .op         (op),
        .rs1_data   (rs1_data),
        .rs2_data   (rs2_data),
        .rd_addr_ex (rd_addr_ex),
        .flush      (flush),
        .busy       (busy),
        .done       (done),
        .result     (result),
        .rd_addr    (rd_addr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [4:0]  rd;
        logic [31:0] exp;
        int          lat;
    } vec_t;

    localparam int NV = 21;
    vec_t vecs [NV];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] rd, input string name);
        @(negedge clk);
        start      = 1'b1;
        op         = o;
        rs1_data   = a;
        rs2_data   = b;
        rd_addr_ex = rd;
        #1;
        chk({name, " busy_at_issue"}, {31'b0, busy}, 32'd1);
    endtask

    // Keeps start high (frozen ID/EX) until done, then drops it before the next edge.
    task automatic wait_done(input logic [31:0] exp, input logic [4:0] rd, input int lat,
                             input string name);
        int got;
        int nbusy;
        logic [31:0] res;
        logic [4:0]  rda;
        got   = 0;
        nbusy = 1;
        res   = '0;
        rda   = '0;
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            #1;
            if (busy) nbusy++;
            if (done) begin
                got = c;
                res = result;
                rda = rd_addr;
                start = 1'b0;
                break;
            end
        end
        chk({name, " done_cycle"}, got, lat);
        chk({name, " busy_cycles"}, nbusy, lat);
        chk({name, " result"}, res, exp);
        chk({name, " rd_addr"}, {27'b0, rda}, {27'b0, rd});
    endtask

    initial begin
        total      = 0;
        bad        = 0;
        rst        = 1'b0;
        start      = 1'b0;
        flush      = 1'b0;
        op         = 3'b000;
        rs1_data   = '0;
        rs2_data   = '0;
        rd_addr_ex = '0;

        //         op      rs1           rs2           rd     expected      lat
        vecs[0]  = '{3'b000, 32'h0000_0007, 32'hFFFF_FFFD, 5'd1,  32'hFFFF_FFEB, 33};
        vecs[1]  = '{3'b001, 32'h0000_0007, 32'hFFFF_FFFD, 5'd2,  32'hFFFF_FFFF, 33};
        vecs[2]  = '{3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd3,  32'hFFFF_FFFE, 33};
        vecs[3]  = '{3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd4,  32'hFFFF_FFFF, 33};
        vecs[4]  = '{3'b100, 32'hFFFF_FFF9, 32'h0000_0002, 5'd5,  32'hFFFF_FFFD, 33};
        vecs[5]  = '{3'b110, 32'hFFFF_FFF9, 32'h0000_0002, 5'd6,  32'hFFFF_FFFF, 33};
        vecs[6]  = '{3'b101, 32'd100,       32'd7,         5'd7,  32'd14,        33};
        vecs[7]  = '{3'b111, 32'd100,       32'd7,         5'd8,  32'd2,         33};
        vecs[8]  = '{3'b100, 32'd1234,      32'h0,         5'd9,  32'hFFFF_FFFF, 1};
        vecs[9]  = '{3'b111, 32'd5,         32'h0,         5'd10, 32'd5,         1};
        vecs[10] = '{3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 5'd11, 32'h8000_0000, 1};
        vecs[11] = '{3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 5'd12, 32'h0000_0000, 1};
        vecs[12] = '{3'b101, 32'd5,         32'h0,         5'd13, 32'hFFFF_FFFF, 1};
        vecs[13] = '{3'b110, 32'hFFFF_FFF9, 32'h0,         5'd14, 32'hFFFF_FFF9, 1};
        vecs[14] = '{3'b000, 32'h1234_5678, 32'h0000_0010, 5'd15, 32'h2345_6780, 33};
        vecs[15] = '{3'b011, 32'h1234_5678, 32'h0000_0010, 5'd16, 32'h0000_0001, 33};
        vecs[16] = '{3'b100, 32'h0000_0007, 32'hFFFF_FFFE, 5'd17, 32'hFFFF_FFFD, 33};
        vecs[17] = '{3'b110, 32'h0000_0007, 32'hFFFF_FFFE, 5'd18, 32'h0000_0001, 33};
        vecs[18] = '{3'b100, 32'h8000_0000, 32'h0000_0001, 5'd19, 32'h8000_0000, 33};
        vecs[19] = '{3'b101, 32'hFFFF_FFFF, 32'h0000_0001, 5'd20, 32'hFFFF_FFFF, 33};
        vecs[20] = '{3'b001, 32'h8000_0000, 32'h8000_0000, 5'd21, 32'h4000_0000, 33};

        repeat (3) @(negedge clk);
        #1;
        chk("reset busy",   {31'b0, busy}, 32'd0);
        chk("reset done",   {31'b0, done}, 32'd0);
        chk("reset result", result, 32'd0);
        chk("reset rd",     {27'b0, rd_addr}, 32'd0);
        @(negedge clk);
        rst = 1'b1;

        // Table: each op issues on the negedge right after the previous done.
        for (int i = 0; i < NV; i++) begin
            issue(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].rd, $sformatf("vec%0d", i));
            wait_done(vecs[i].exp, vecs[i].rd, vecs[i].lat, $sformatf("vec%0d", i));
        end

        // Flush at N+10 of a DIV: no done, IDLE at N+11, then a MUL at N+12.
        begin
            int seen_done;
            seen_done = 0;
            issue(3'b101, 32'd100, 32'd7, 5'd25, "flush_div");
            for (int c = 1; c <= 10; c++) begin
                @(negedge clk);
                if (c == 10) flush = 1'b1;
                #1;
                if (done) seen_done++;
            end
            @(negedge clk);
            flush = 1'b0;
            start = 1'b0;
            #1;
            if (done) seen_done++;
            chk("flush no_done", seen_done, 0);
            chk("flush idle_busy", {31'b0, busy}, 32'd0);
            chk("flush result_hold", result, 32'h4000_0000);
            chk("flush rd_hold", {27'b0, rd_addr}, 32'd21);
            issue(3'b000, 32'h0000_0007, 32'hFFFF_FFFD, 5'd26, "after_flush_mul");
            wait_done(32'hFFFF_FFEB, 5'd26, 33, "after_flush_mul");
        end

        // flush together with start in IDLE: not accepted.
        @(negedge clk);
        start    = 1'b1;
        flush    = 1'b1;
        op       = 3'b000;
        rs1_data = 32'd3;
        rs2_data = 32'd3;
        #1;
        chk("flush_start busy", {31'b0, busy}, 32'd0);
        @(negedge clk);
        start = 1'b0;
        flush = 1'b0;
        #1;
        chk("flush_start not_accepted", {31'b0, busy}, 32'd0);
        chk("flush_start no_done", {31'b0, done}, 32'd0);
        chk("flush_start result_hold", result, 32'hFFFF_FFEB);

        // Async reset at N+5 of a MUL; start stays high and is re-accepted on release.
        issue(3'b000, 32'd6, 32'd9, 5'd27, "rst_mul");
        repeat (4) @(negedge clk);
        @(negedge clk);
        #2;
        rst = 1'b0;
        #1;
        chk("midrst busy",   {31'b0, busy}, 32'd0);
        chk("midrst done",   {31'b0, done}, 32'd0);
        chk("midrst result", result, 32'd0);
        chk("midrst rd",     {27'b0, rd_addr}, 32'd0);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("rst_release busy", {31'b0, busy}, 32'd1);
        wait_done(32'd54, 5'd27, 33, "rst_release_mul");

        @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
